// File: rtl/dram_port_scheduler_if.sv
// dram_port_scheduler_if
// Bundles the requester-side handshakes and the RAM-primitive pins of the
// distributed-RAM port scheduler.
//
// Handshake rule (both channels): a requester raises *_valid with stable
// bank/data and holds it until it sees *_ready high in the same cycle; the
// transfer is accepted on the rising edge where valid && ready. Dropping
// valid before ready cancels the request without side effects.
//
// Signals:
//   wr_valid/wr_ready/wr_bank/wr_data : word-write request channel
//   rd_valid/rd_ready/rd_bank         : word-read request channel
//   rd_data/rd_done                   : read result and its one-cycle strobe
//   busy                              : a bit-serial transfer is running
//   ram_addr/ram_we/ram_d/ram_o       : 1-bit RAM primitive pins
// Modports:
//   master : requester side
//   slave  : scheduler side
//   ram    : RAM primitive side
interface dram_port_if #(
    parameter int IO_WIDTH   = 16,
    parameter int ADDR_WIDTH = 7
);
    localparam int BANK_WIDTH = ADDR_WIDTH - $clog2(IO_WIDTH);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [BANK_WIDTH-1:0] wr_bank;
    logic [IO_WIDTH-1:0]   wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [BANK_WIDTH-1:0] rd_bank;
    logic [IO_WIDTH-1:0]   rd_data;
    logic                  rd_done;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic                  ram_d;
    logic                  ram_o;

    modport master (
        output wr_valid, wr_bank, wr_data, rd_valid, rd_bank,
        input  wr_ready, rd_ready, rd_data, rd_done, busy
    );

    modport slave (
        input  wr_valid, wr_bank, wr_data, rd_valid, rd_bank, ram_o,
        output wr_ready, rd_ready, rd_data, rd_done, busy,
               ram_addr, ram_we, ram_d
    );

    modport ram (
        input  ram_addr, ram_we, ram_d,
        output ram_o
    );
endinterface

// File: rtl/dram_port_scheduler.sv
// dram_port_scheduler
// Owns the single shared address port of a 1-bit-wide distributed RAM
// (synchronous write, asynchronous read). Words of IO_WIDTH bits live in
// banks of IO_WIDTH consecutive RAM bits and are moved bit-serially, bit 0
// first. A write requester and a read requester share the port; ties are
// broken round-robin against the last grant (write wins the first tie).
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : dram_port_if.slave (handshakes, read result, RAM pins)
//   dbg_state : current FSM state (0 idle, 1 write, 2 read)
//
// Timing: handshake in cycle N, transfer in N+1..N+IO_WIDTH, next handshake
// possible in N+IO_WIDTH+1, rd_done high in N+IO_WIDTH+1.
module dram_port_scheduler #(
    parameter int IO_WIDTH   = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    dram_port_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int CNT_WIDTH  = $clog2(IO_WIDTH);
    localparam int BANK_WIDTH = ADDR_WIDTH - CNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    typedef enum logic {
        G_WRITE = 1'b0,
        G_READ  = 1'b1
    } grant_t;

    state_t                state;
    grant_t                last_grant;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  cnt_last;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [IO_WIDTH-1:0]   word_q;
    logic [IO_WIDTH-1:0]   shadow;
    logic [IO_WIDTH-1:0]   shadow_next;
    logic                  wr_go;
    logic                  rd_go;

    // Round-robin pick: a lone requester always wins, on a tie the one not
    // served last time wins. Readies are gated with rst_n so nothing is
    // offered while reset is held.
    assign wr_go = rst_n && (state == S_IDLE) && bus.wr_valid &&
                   (!bus.rd_valid || (last_grant == G_READ));
    assign rd_go = rst_n && (state == S_IDLE) && bus.rd_valid &&
                   (!bus.wr_valid || (last_grant == G_WRITE));

    assign bus.wr_ready = wr_go;
    assign bus.rd_ready = rd_go;
    assign dbg_state    = state;

    assign cnt_next = cnt + 1'b1;
    assign cnt_last = (cnt == {CNT_WIDTH{1'b1}});

    // Shadow word including the bit arriving on this edge, so the final
    // bit lands in rd_data on the same edge it is sampled.
    always_comb begin
        shadow_next      = shadow;
        shadow_next[cnt] = bus.ram_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            last_grant   <= G_READ;
            cnt          <= '0;
            bank_q       <= '0;
            word_q       <= '0;
            shadow       <= '0;
            bus.rd_data  <= '0;
            bus.rd_done  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_d    <= 1'b0;
        end else begin
            bus.rd_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_go) begin
                        bank_q       <= bus.wr_bank;
                        word_q       <= bus.wr_data;
                        cnt          <= '0;
                        last_grant   <= G_WRITE;
                        bus.ram_addr <= {bus.wr_bank, {CNT_WIDTH{1'b0}}};
                        bus.ram_d    <= bus.wr_data[0];
                        bus.ram_we   <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= S_WRITE;
                    end else if (rd_go) begin
                        bank_q       <= bus.rd_bank;
                        cnt          <= '0;
                        last_grant   <= G_READ;
                        bus.ram_addr <= {bus.rd_bank, {CNT_WIDTH{1'b0}}};
                        bus.ram_we   <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= S_READ;
                    end else begin
                        // ram_addr intentionally holds its last value
                        bus.ram_we <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (cnt_last) begin
                        bus.ram_we <= 1'b0;
                        bus.busy   <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        cnt          <= cnt_next;
                        bus.ram_addr <= {bank_q, cnt_next};
                        bus.ram_d    <= word_q[cnt_next];
                    end
                end
                S_READ: begin
                    shadow <= shadow_next;
                    if (cnt_last) begin
                        bus.rd_data <= shadow_next;
                        bus.rd_done <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        cnt          <= cnt_next;
                        bus.ram_addr <= {bank_q, cnt_next};
                    end
                end
                default: begin
                    bus.ram_we <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_port_scheduler.sv
// tb_dram_port_scheduler
// Directed bench for dram_port_scheduler with a behavioural 128x1 RAM
// (synchronous write, asynchronous read, preloaded with 16'h96A5 per bank).
module tb_dram_port_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;

    int checks = 0;
    int errors = 0;

    dram_port_if #(.IO_WIDTH(16), .ADDR_WIDTH(7)) bus ();

    dram_port_scheduler #(.IO_WIDTH(16), .ADDR_WIDTH(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    logic [127:0] mem = {8{16'h96A5}};
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
    assign bus.ram_o = mem[bus.ram_addr];

    // ---------------- monitors ----------------
    int         we_cnt = 0;
    int         overlap_cnt = 0;
    logic [6:0] wr_addr_q[$];

    always @(posedge clk) begin
        if (bus.ram_we) begin
            we_cnt++;
            wr_addr_q.push_back(bus.ram_addr);
        end
    end

    always @(negedge clk) begin
        if (bus.busy && (bus.wr_ready || bus.rd_ready)) overlap_cnt++;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic [2:0] bank, input logic [15:0] data, output int hs);
        logic seen;
        seen = 1'b0;
        hs   = -1;
        @(posedge clk); #1;
        bus.wr_bank  = bank;
        bus.wr_data  = data;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                seen = 1'b1;
                hs   = cyc;
            end
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        check("wr_handshake", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_read(input logic [2:0] bank, output logic [15:0] word, output int lat);
        logic seen;
        logic done;
        int   hs;
        seen = 1'b0;
        done = 1'b0;
        hs   = 0;
        lat  = -1;
        word = 16'hxxxx;
        @(posedge clk); #1;
        bus.rd_bank  = bank;
        bus.rd_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                seen = 1'b1;
                hs   = cyc;
            end
        end
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        for (int i = 0; i < 40 && seen && !done; i++) begin
            @(negedge clk);
            if (bus.rd_done) begin
                done = 1'b1;
                lat  = cyc - hs;
                word = bus.rd_data;
            end
        end
        check("rd_complete", {30'd0, seen, done}, 32'd3);
        @(negedge clk);
        check("rd_done_pulse", {31'd0, bus.rd_done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] w;
    int          lat;
    int          hs;
    int          hs_arr[8];
    logic [15:0] words[8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000,
                              16'h1234, 16'hBEEF, 16'h5555, 16'hAAAA};
    logic        g_kind[4];
    int          g_cyc[4];
    logic [15:0] rd_words[2];
    int          ng;
    int          nr;
    int          rd_seen;
    int          done_seen;

    initial begin
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        bus.wr_bank  = '0;
        bus.rd_bank  = '0;
        bus.wr_data  = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we",   {31'd0, bus.ram_we},   32'd0);
        check("rst_ram_addr", {25'd0, bus.ram_addr}, 32'd0);
        check("rst_ram_d",    {31'd0, bus.ram_d},    32'd0);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_rd_done",  {31'd0, bus.rd_done},  32'd0);
        check("rst_rd_data",  {16'd0, bus.rd_data},  32'd0);
        check("rst_state",    {30'd0, dbg_state},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: read after reset
        we_cnt = 0;
        do_read(3'd0, w, lat);
        check("t1_data",   {16'd0, w}, 32'h96A5);
        check("t1_lat",    lat,        32'd17);
        check("t1_no_we",  we_cnt,     32'd0);

        // 5: reset during the 6th write cycle, after 5 bits have been stored
        do_write(3'd1, 16'h5A5A, hs);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_we_drop",   {31'd0, bus.ram_we},  32'd0);
        check("t5_busy_drop", {31'd0, bus.busy},    32'd0);
        check("t5_state",     {30'd0, dbg_state},   32'd0);
        check("t5_rd_data0",  {16'd0, bus.rd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(3'd1, w, lat);
        check("t5_merged", {16'd0, w}, 32'h96BA);

        // 2: write then read same bank, address order, neighbour intact
        wr_addr_q.delete();
        do_write(3'd3, 16'hA5C3, hs);
        do_read(3'd3, w, lat);
        check("t2_data", {16'd0, w}, 32'hA5C3);
        check("t2_nwr",  wr_addr_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++)
            check("t2_addr", {25'd0, wr_addr_q[i]}, 32'(48 + i));
        do_read(3'd2, w, lat);
        check("t2_bank2", {16'd0, w}, 32'h96A5);

        // 3: both requests held from reset -> W,R,W,R
        rst_n        = 1'b0;
        bus.wr_bank  = 3'd5;
        bus.wr_data  = 16'hC0DE;
        bus.rd_bank  = 3'd5;
        bus.wr_valid = 1'b1;
        bus.rd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t3_rst_ready", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 120 && nr < 2; i++) begin
            @(negedge clk);
            if (bus.wr_ready && ng < 4) begin
                g_kind[ng] = 1'b0;
                g_cyc[ng]  = cyc;
                ng++;
            end else if (bus.rd_ready && ng < 4) begin
                g_kind[ng] = 1'b1;
                g_cyc[ng]  = cyc;
                ng++;
            end
            if (bus.rd_done && nr < 2) begin
                rd_words[nr] = bus.rd_data;
                nr++;
            end
            @(posedge clk); #1;
            if (ng >= 4) begin
                bus.wr_valid = 1'b0;
                bus.rd_valid = 1'b0;
            end
        end
        check("t3_ngrants", ng, 32'd4);
        check("t3_nreads",  nr, 32'd2);
        if (ng == 4) begin
            check("t3_order", {28'd0, g_kind[0], g_kind[1], g_kind[2], g_kind[3]}, 32'b0101);
            for (int i = 1; i < 4; i++)
                check("t3_gap", g_cyc[i] - g_cyc[i-1], 32'd17);
        end
        if (nr == 2) begin
            check("t3_rd0", {16'd0, rd_words[0]}, 32'hC0DE);
            check("t3_rd1", {16'd0, rd_words[1]}, 32'hC0DE);
        end
        check("t3_overlap", overlap_cnt, 32'd0);

        // 6: one-cycle read pulse while a write is busy
        do_write(3'd6, 16'h0F0F, hs);
        rd_seen   = 0;
        done_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        bus.rd_bank  = 3'd6;
        bus.rd_valid = 1'b1;
        @(negedge clk);
        if (bus.rd_ready) rd_seen++;
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.rd_ready) rd_seen++;
            if (bus.rd_done)  done_seen++;
        end
        check("t6_no_ready", rd_seen,   32'd0);
        check("t6_no_done",  done_seen, 32'd0);
        check("t6_idle",     {30'd0, dbg_state}, 32'd0);
        check("t6_not_busy", {31'd0, bus.busy},  32'd0);

        // 4: back-to-back writes to every bank, then read all back
        @(posedge clk); #1;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic seen;
            seen       = 1'b0;
            hs_arr[i]  = -1;
            bus.wr_bank = 3'(i);
            bus.wr_data = words[i];
            for (int j = 0; j < 60 && !seen; j++) begin
                @(negedge clk);
                if (bus.wr_ready) begin
                    seen      = 1'b1;
                    hs_arr[i] = cyc;
                end
            end
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        for (int i = 1; i < 8; i++)
            check("t4_gap", hs_arr[i] - hs_arr[i-1], 32'd17);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), w, lat);
            check("t4_data", {16'd0, w}, {16'd0, words[i]});
        end
        check("final_overlap", overlap_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dram_port_scheduler.md
Name: dram_port_scheduler

Overview:
Owns the single address port of a 1-bit-wide distributed RAM (RAM128X1S-class: synchronous write, asynchronous read, shared read/write address). It time-multiplexes that port between a word-write requester and a word-read requester. Each IO_WIDTH-bit word occupies one bank of IO_WIDTH consecutive RAM bits and is transferred bit-serially. The block sits between switch/LED-side logic and the RAM primitive in the dram_shifter tests, replacing ad-hoc address sequencing.

Parameters:
IO_WIDTH, 16, bits per word and per bank; power of 2, at most 2^ADDR_WIDTH.
ADDR_WIDTH, 7, RAM address width (7 for a 128x1 RAM).
BANK_WIDTH, ADDR_WIDTH-log2(IO_WIDTH) (3 by default), derived bank index width; not overridden.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_valid  in  1  write request; held until wr_ready.
wr_ready  out  1  write accepted this cycle.
wr_bank  in  BANK_WIDTH  target bank.
wr_data  in  IO_WIDTH  word to store.
rd_valid  in  1  read request; held until rd_ready.
rd_ready  out  1  read accepted this cycle.
rd_bank  in  BANK_WIDTH  source bank.
rd_data  out  IO_WIDTH  last completed read word; stable between reads.
rd_done  out  1  one-cycle pulse when rd_data updates.
busy  out  1  high while a transfer is in progress.
ram_addr  out  ADDR_WIDTH  to RAM A[ADDR_WIDTH-1:0]; {bank, bit index}.
ram_we  out  1  to RAM WE.
ram_d  out  1  to RAM D.
ram_o  in  1  from RAM O (asynchronous read data).

Behaviour:
- Reset (async assert, sync release): state IDLE; ram_we=0, ram_addr=0, ram_d=0, rd_data=0, rd_done=0, busy=0, wr_ready=0, rd_ready=0, last_grant=READ (write wins the first tie).
- States: IDLE, WRITE, READ. Bit counter cnt is log2(IO_WIDTH) bits wide.
- IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not named by last_grant is granted.
  - Grant: the granted ready goes high combinationally in the same cycle (ready = IDLE && grant && valid). The other ready stays 0.
  - On handshake: latch bank and data, cnt<=0, last_grant updated, go to WRITE or READ.
  - With no request: ram_we=0 and ram_addr holds its last value.
- WRITE: ram_addr={bank,cnt}, ram_d=word[cnt], ram_we=1, all registered outputs. Runs for exactly IO_WIDTH cycles, bit 0 first. After cnt=IO_WIDTH-1 the block returns to IDLE with ram_we=0.
- READ: ram_addr={bank,cnt}, ram_we=0. On each edge, capture ram_o into shadow bit cnt. After the edge with cnt=IO_WIDTH-1:
  - rd_data <= the full shadow word;
  - rd_done=1 for exactly one cycle;
  - return to IDLE.
- Timing: handshake in cycle N; transfer in cycles N+1..N+IO_WIDTH; the next handshake is possible at cycle N+IO_WIDTH+1. Peak rate is one word per IO_WIDTH+1 cycles. Read latency: rd_done is high in cycle N+IO_WIDTH+1.
- busy=1 exactly while in WRITE or READ. Both readies are 0 whenever busy=1.
- Ordering: a read accepted after a write completes always returns the written data, including for the same bank. No write/read overlap exists.
- Valid dropped before ready: there is no transfer and no state change.
- Bank decoding: with the derived BANK_WIDTH, every bank index is legal and addresses never overlap between banks.
- Reset mid-transfer: abort immediately, drop ram_we asynchronously, return to reset values. Bits already written remain in RAM (RAM contents are not reset). A request still valid after reset release is serviced normally.

Test Plan:
1. Read-after-reset: RAM model with INIT 128'h96A5_..._96A5; read bank 0 -> rd_data=16'h96A5, rd_done exactly at handshake+17 cycles, ram_we never 1.
2. Write then read: write bank 3 with 16'hA5C3, then read bank 3 -> rd_data=16'hA5C3. RAM addresses 48..63 written in ascending order, one per cycle. Bank 2 (read back) still holds 16'h96A5.
3. Simultaneous requests: wr_valid and rd_valid both held high from reset -> grants alternate W,R,W,R. Each handshake is 17 cycles apart; no ready is asserted while busy.
4. Back-to-back writes: write 8 distinct words to banks 0..7 with wr_valid held continuously, then read all 8 -> every word matches, and throughput is exactly 17 cycles per word.
5. Reset mid-write: assert rst_n=0 during cycle 5 of a write to bank 1 -> ram_we drops at once. After release, reading bank 1 returns the new low 5 bits merged with the 16'h96A5 upper bits; rd_data was 0 before that read.
6. Valid withdrawal: rd_valid pulsed for one cycle while a write is busy -> no read occurs, rd_done stays 0, state returns to IDLE.
